countdown_timer: RTL

// - Down-counting hh:mm:ss timer; the counting-backwards counterpart of the free-running up-counting clock.
// - Loaded with a start time, counts down once per T_HOLD clk cycles, stops at 00:00:00 and raises an alarm.
// - Its number output uses the same packed format as the clock (hh*10000 + mm*100 + ss), so it can share the display path.

---
 rtl/countdown_timer_if.sv | 32 +++
 rtl/countdown_timer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer: load value and strobes in, state flags and packed time out.
// Combinational wires only; the bundle adds no delay.
// No handshake; every strobe is sampled on the next clk edge.
//
// load / load_hours / load_minutes / load_seconds : capture a start time (clamped inside the timer)
// start / pause                                   : 1-cycle control strobes
// running / done / alarm                          : RUN level, expiry pulse, EXPIRED level
// number                                          : hh*10000 + mm*100 + ss, binary
interface countdown_timer_if;
    logic        load;
    logic [7:0]  load_hours;
    logic [7:0]  load_minutes;
    logic [7:0]  load_seconds;
    logic        start;
    logic        pause;
    logic        running;
    logic        done;
    logic        alarm;
    logic [23:0] number;

    // master drives the controls and reads the status
    modport master (
        output load, load_hours, load_minutes, load_seconds, start, pause,
        input  running, done, alarm, number
    );

    // slave is the timer itself
    modport slave (
        input  load, load_hours, load_minutes, load_seconds, start, pause,
        output running, done, alarm, number
    );
endinterface

// File: rtl/countdown_timer.sv
// Down-counting hh:mm:ss timer that stops at 00:00:00 and raises an alarm.
// Strobes act on the next clk edge; one second elapses every T_HOLD cycles spent in RUN.
// No backpressure; load beats pause, and pause beats start, when strobes coincide.
//
// Ports:
//   clk   system clock
//   rst   asynchronous, active-high reset
//   bus   countdown_timer_if.slave: load/start/pause strobes and start time in,
//         running/done/alarm flags and the packed number out
module countdown_timer #(
    parameter int T_HOLD       = 100_000_000,
    parameter int T_HOLD_WIDTH = (T_HOLD > 1) ? $clog2(T_HOLD) : 1
) (
    input  logic              clk,
    input  logic              rst,
    countdown_timer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [T_HOLD_WIDTH-1:0] TICK_LAST = T_HOLD_WIDTH'(T_HOLD - 1);
    localparam logic [T_HOLD_WIDTH-1:0] TICK_ONE  = T_HOLD_WIDTH'(1);

    state_t                  state;
    state_t                  state_nxt;
    logic [4:0]              hh;
    logic [4:0]              hh_nxt;
    logic [5:0]              mm;
    logic [5:0]              mm_nxt;
    logic [5:0]              ss;
    logic [5:0]              ss_nxt;
    logic [T_HOLD_WIDTH-1:0] tick;
    logic [T_HOLD_WIDTH-1:0] tick_nxt;
    logic                    done_q;
    logic                    done_nxt;

    // Load value after clamping to the legal range of each field.
    logic [4:0] load_hh;
    logic [5:0] load_mm;
    logic [5:0] load_ss;

    always_comb begin
        load_hh = (bus.load_hours   > 8'd23) ? 5'd23 : bus.load_hours[4:0];
        load_mm = (bus.load_minutes > 8'd59) ? 6'd59 : bus.load_minutes[5:0];
        load_ss = (bus.load_seconds > 8'd59) ? 6'd59 : bus.load_seconds[5:0];
    end

    // One-second decrement with borrow from minutes and hours. At 00:00:00 the
    // value is held, so the counter can never wrap.
    logic [4:0] dec_hh;
    logic [5:0] dec_mm;
    logic [5:0] dec_ss;
    logic       dec_zero;
    logic       time_zero;

    always_comb begin
        dec_hh = hh;
        dec_mm = mm;
        dec_ss = ss;
        if (ss != 6'd0) begin
            dec_ss = ss - 6'd1;
        end else if (mm != 6'd0) begin
            dec_ss = 6'd59;
            dec_mm = mm - 6'd1;
        end else if (hh != 5'd0) begin
            dec_ss = 6'd59;
            dec_mm = 6'd59;
            dec_hh = hh - 5'd1;
        end
    end

    assign time_zero = (hh == 5'd0) && (mm == 6'd0) && (ss == 6'd0);
    assign dec_zero  = (dec_hh == 5'd0) && (dec_mm == 6'd0) && (dec_ss == 6'd0);

    // Next-state and datapath logic.
    always_comb begin
        state_nxt = state;
        hh_nxt    = hh;
        mm_nxt    = mm;
        ss_nxt    = ss;
        tick_nxt  = tick;
        done_nxt  = 1'b0;

        if (bus.load) begin
            // Load overrides everything and returns to IDLE from any state,
            // which also drops the alarm.
            state_nxt = IDLE;
            hh_nxt    = load_hh;
            mm_nxt    = load_mm;
            ss_nxt    = load_ss;
            tick_nxt  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // A zero start time has nothing to count, so start is ignored.
                    if (!bus.pause && bus.start && !time_zero) begin
                        state_nxt = RUN;
                        tick_nxt  = '0;
                    end
                end
                RUN: begin
                    if (bus.pause) begin
                        // tick is kept so a resume finishes the partial second.
                        state_nxt = PAUSED;
                    end else if (tick == TICK_LAST) begin
                        tick_nxt = '0;
                        hh_nxt   = dec_hh;
                        mm_nxt   = dec_mm;
                        ss_nxt   = dec_ss;
                        if (dec_zero) begin
                            state_nxt = EXPIRED;
                            done_nxt  = 1'b1;
                        end
                    end else begin
                        tick_nxt = tick + TICK_ONE;
                    end
                end
                PAUSED: begin
                    if (!bus.pause && bus.start) begin
                        state_nxt = RUN;
                    end
                end
                EXPIRED: begin
                    // pause has no meaning here; start acknowledges the alarm.
                    if (bus.start) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            hh     <= 5'd0;
            mm     <= 6'd0;
            ss     <= 6'd0;
            tick   <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            hh     <= hh_nxt;
            mm     <= mm_nxt;
            ss     <= ss_nxt;
            tick   <= tick_nxt;
            done_q <= done_nxt;
        end
    end

    assign bus.running = (state == RUN);
    assign bus.alarm   = (state == EXPIRED);
    assign bus.done    = done_q;
    // Products are widened to 24 bits before multiplying so 23*10000 fits.
    assign bus.number  = (24'(hh) * 24'd10000) + (24'(mm) * 24'd100) + 24'(ss);

endmodule
